pc_seq_unit: RTL and testbench

- Parametrised program counter for the processor fetch stage; successor to the plain increment-only PC.
- Adds relative branch, absolute jump, call/return via an internal LIFO return stack, and a halt state.
- Drives the program-memory address; the decode stage supplies the op, target and offset each cycle.

---
 rtl/pc_pkg.sv | 14 +
 rtl/pc_ret_stack.sv | 48 ++++
 rtl/pc_seq_unit.sv | 76 +++++++
 tb/tb_pc_seq_unit.sv | 156 +++++++++++++++
 4 files changed

// File: rtl/pc_pkg.sv
// pc_pkg: shared op encoding for the program-counter sequencer.
// Contents: OP_W (op field width) and the OP_* operation codes.
package pc_pkg;

    localparam int OP_W = 3;

    localparam logic [OP_W-1:0] OP_NEXT   = 3'd0;
    localparam logic [OP_W-1:0] OP_BRANCH = 3'd1;
    localparam logic [OP_W-1:0] OP_JUMP   = 3'd2;
    localparam logic [OP_W-1:0] OP_CALL   = 3'd3;
    localparam logic [OP_W-1:0] OP_RET    = 3'd4;
    localparam logic [OP_W-1:0] OP_HALT   = 3'd5;

endpackage

// File: rtl/pc_ret_stack.sv
// pc_ret_stack: synchronous LIFO holding return addresses.
// Ports: clk, reset (async, active-high), push, pop, din -> top, level, full, empty.
// The caller must not push when full or pop when empty.
module pc_ret_stack #(
    parameter int ADDR_W      = 11,
    parameter int STACK_DEPTH = 4
) (
    input  logic                                 clk,
    input  logic                                 reset,
    input  logic                                 push,
    input  logic                                 pop,
    input  logic [ADDR_W-1:0]                    din,
    output logic [ADDR_W-1:0]                    top,
    output logic [$clog2(STACK_DEPTH+1)-1:0]     level,
    output logic                                 full,
    output logic                                 empty
);

    localparam int LVL_W = $clog2(STACK_DEPTH + 1);
    localparam int IDX_W = STACK_DEPTH > 1 ? $clog2(STACK_DEPTH) : 1;

    logic [ADDR_W-1:0] mem [STACK_DEPTH];
    logic [IDX_W-1:0]  wr_idx;
    logic [IDX_W-1:0]  rd_idx;

    // level counts valid entries, so the next free slot is level and the top is level-1
    assign wr_idx = IDX_W'(level);
    assign rd_idx = IDX_W'(level - LVL_W'(1));
    assign top    = mem[rd_idx];
    assign full   = level == LVL_W'(STACK_DEPTH);
    assign empty  = level == '0;

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            level <= '0;
        else if (push)
            level <= level + LVL_W'(1);
        else if (pop)
            level <= level - LVL_W'(1);
    end

    // contents need no reset: entries above level are never read
    always_ff @(posedge clk) begin
        if (push)
            mem[wr_idx] <= din;
    end

endmodule

// File: rtl/pc_seq_unit.sv
// pc_seq_unit: fetch-stage program counter with branch, jump, call/return and halt.
// Ports: clk, reset (async, active-high), enable, op, target, offset ->
//        addr (registered), halted, stack_level, ovf, unf (sticky flags).
module pc_seq_unit
    import pc_pkg::*;
#(
    parameter int                ADDR_W      = 11,
    parameter int                STACK_DEPTH = 4,
    parameter logic [ADDR_W-1:0] RESET_ADDR  = '0
) (
    input  logic                                 clk,
    input  logic                                 reset,
    input  logic                                 enable,
    input  logic [OP_W-1:0]                      op,
    input  logic [ADDR_W-1:0]                    target,
    input  logic [ADDR_W-1:0]                    offset,
    output logic [ADDR_W-1:0]                    addr,
    output logic                                 halted,
    output logic [$clog2(STACK_DEPTH+1)-1:0]     stack_level,
    output logic                                 ovf,
    output logic                                 unf
);

    logic              run;
    logic              push;
    logic              pop;
    logic              full;
    logic              empty;
    logic [ADDR_W-1:0] top;
    logic [ADDR_W-1:0] ret_addr;
    logic [ADDR_W-1:0] addr_nxt;

    assign run      = enable && !halted;
    assign ret_addr = addr + ADDR_W'(1);
    assign push     = run && op == OP_CALL && !full;
    assign pop      = run && op == OP_RET && !empty;

    // rejected CALL/RET and reserved ops all fall through to addr+1
    always_comb begin
        addr_nxt = op == OP_BRANCH           ? addr + offset :
                   (op == OP_JUMP || push)   ? target :
                   pop                       ? top :
                   op == OP_HALT             ? addr :
                                               ret_addr;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            addr   <= RESET_ADDR;
            halted <= 1'b0;
            ovf    <= 1'b0;
            unf    <= 1'b0;
        end else if (run) begin
            addr   <= addr_nxt;
            halted <= halted || op == OP_HALT;
            ovf    <= ovf || (op == OP_CALL && full);
            unf    <= unf || (op == OP_RET && empty);
        end
    end

    pc_ret_stack #(
        .ADDR_W      (ADDR_W),
        .STACK_DEPTH (STACK_DEPTH)
    ) u_stack (
        .clk   (clk),
        .reset (reset),
        .push  (push),
        .pop   (pop),
        .din   (ret_addr),
        .top   (top),
        .level (stack_level),
        .full  (full),
        .empty (empty)
    );

endmodule

// File: tb/tb_pc_seq_unit.sv
// tb_pc_seq_unit: scoreboard bench for pc_seq_unit with directed, hand-computed vectors.
module tb_pc_seq_unit;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        enable = 1'b0;
    logic [2:0]  op = 3'd0;
    logic [10:0] target = '0;
    logic [10:0] offset = '0;
    logic [10:0] addr;
    logic        halted;
    logic [2:0]  stack_level;
    logic        ovf;
    logic        unf;

    int checks = 0;
    int errors = 0;
    int step_no = 0;

    typedef struct {
        string       nm;
        logic [10:0] a;
        logic [2:0]  l;
        logic        h;
        logic        o;
        logic        u;
    } exp_t;

    exp_t sb[$];

    localparam logic [2:0] NX = 3'd0, BR = 3'd1, JP = 3'd2, CL = 3'd3, RT = 3'd4, HT = 3'd5;

    pc_seq_unit #(.ADDR_W(11), .STACK_DEPTH(4), .RESET_ADDR(11'd0)) dut (
        .clk         (clk),
        .reset       (reset),
        .enable      (enable),
        .op          (op),
        .target      (target),
        .offset      (offset),
        .addr        (addr),
        .halted      (halted),
        .stack_level (stack_level),
        .ovf         (ovf),
        .unf         (unf)
    );

    always #5 clk = ~clk;

    task automatic cmp(input string nm, input logic [10:0] a, input logic [2:0] l,
                       input logic h, input logic o, input logic u);
        checks++;
        if (addr !== a || stack_level !== l || halted !== h || ovf !== o || unf !== u) begin
            errors++;
            $display("FAIL %s: got addr=%0d lvl=%0d h=%b o=%b u=%b, want addr=%0d lvl=%0d h=%b o=%b u=%b",
                     nm, addr, stack_level, halted, ovf, unf, a, l, h, o, u);
        end
    endtask

    // monitor: every outstanding expectation is settled 1 time unit after its edge
    initial forever begin
        @(posedge clk);
        #1;
        if (sb.size() != 0) begin
            exp_t e;
            e = sb.pop_front();
            cmp(e.nm, e.a, e.l, e.h, e.o, e.u);
        end
    end

    task automatic step(input logic en, input logic [2:0] o, input logic [10:0] t,
                        input logic [10:0] f, input logic [10:0] ea, input logic [2:0] el,
                        input logic eh, input logic eo, input logic eu);
        exp_t e;
        @(negedge clk);
        enable = en;
        op     = o;
        target = t;
        offset = f;
        step_no++;
        e.nm = $sformatf("step%0d", step_no);
        e.a = ea; e.l = el; e.h = eh; e.o = eo; e.u = eu;
        sb.push_back(e);
    endtask

    // reset asserted between edges; outputs must clear without a clock
    task automatic mid_reset(input string nm);
        @(negedge clk);
        enable = 1'b0;
        #2 reset = 1'b1;
        #1 cmp(nm, 11'd0, 3'd0, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        reset = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, required completion");
        $fatal(1);
    end

    initial begin
        #3 cmp("reset", 11'd0, 3'd0, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        reset = 1'b0;
        for (int i = 1; i <= 5; i++) step(1, NX, 0, 0, 11'(i), 0, 0, 0, 0);
        for (int i = 0; i < 3; i++) step(0, NX, 0, 0, 5, 0, 0, 0, 0);
        step(1, JP, 10, 0, 10, 0, 0, 0, 0);
        step(1, BR, 0, 11'h7FD, 7, 0, 0, 0, 0);
        step(1, BR, 0, 5, 12, 0, 0, 0, 0);
        step(1, JP, 2047, 0, 2047, 0, 0, 0, 0);
        step(1, NX, 0, 0, 0, 0, 0, 0, 0);
        step(1, JP, 20, 0, 20, 0, 0, 0, 0);
        step(1, CL, 100, 0, 100, 1, 0, 0, 0);
        step(1, CL, 200, 0, 200, 2, 0, 0, 0);
        step(1, RT, 0, 0, 101, 1, 0, 0, 0);
        step(1, RT, 0, 0, 21, 0, 0, 0, 0);
        step(1, JP, 2047, 0, 2047, 0, 0, 0, 0);
        step(1, CL, 300, 0, 300, 1, 0, 0, 0);
        step(1, RT, 0, 0, 0, 0, 0, 0, 0);
        step(1, CL, 50, 0, 50, 1, 0, 0, 0);
        step(1, CL, 60, 0, 60, 2, 0, 0, 0);
        step(1, CL, 70, 0, 70, 3, 0, 0, 0);
        step(1, CL, 80, 0, 80, 4, 0, 0, 0);
        step(1, CL, 90, 0, 81, 4, 0, 1, 0);
        step(1, RT, 0, 0, 71, 3, 0, 1, 0);
        step(1, RT, 0, 0, 61, 2, 0, 1, 0);
        step(1, RT, 0, 0, 51, 1, 0, 1, 0);
        step(1, RT, 0, 0, 1, 0, 0, 1, 0);
        mid_reset("reset_clears_ovf");
        step(1, RT, 0, 0, 1, 0, 0, 0, 1);
        mid_reset("reset_clears_unf");
        step(1, JP, 30, 0, 30, 0, 0, 0, 0);
        step(1, HT, 0, 0, 30, 0, 1, 0, 0);
        for (int i = 0; i < 10; i++)
            step(1'(i % 3 != 0), 3'(i % 6), 11'd500, 11'd9, 30, 0, 1, 0, 0);
        mid_reset("reset_clears_halt");
        step(1, JP, 40, 0, 40, 0, 0, 0, 0);
        step(1, 3'd6, 0, 0, 41, 0, 0, 0, 0);
        step(1, 3'd7, 0, 0, 42, 0, 0, 0, 0);
        step(1, CL, 100, 0, 100, 1, 0, 0, 0);
        step(1, CL, 200, 0, 200, 2, 0, 0, 0);
        mid_reset("reset_mid_calls");
        step(1, RT, 0, 0, 1, 0, 0, 0, 1);
        @(negedge clk);
        enable = 1'b0;
        @(negedge clk);
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d expectations left, required 0", sb.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
